// File: rtl/data_ram_mp_if.sv
// Request/response bundle for data_ram_mp, one lane per MEM-stage issue slot.
//
// Handshake: a request on port i transfers on a rising edge where
// req_valid[i] and req_ready[i] are both high. req_ready[i] never depends on
// req_valid[i]. A requester that sees req_ready[i] low keeps its request
// unchanged until it transfers. Loads answer exactly one cycle after transfer
// on rsp_valid/rsp_rdata. There is no back-pressure on responses.
//
// Signals (port i occupies slice i of each vector):
//   req_valid, req_ready, req_we        one bit per port
//   req_addr, req_wdata, rsp_rdata      32 bits per port
//   req_sel                             4 byte enables per port
//   rsp_valid                           one bit per port
//   fsm_run                             debug view of the sequencer (1 = RUN)
// Modports: master = requester side, slave = RAM side.
interface data_ram_mp_if #(
  parameter int NPORT = 2
);
  logic [NPORT-1:0]    req_valid;
  logic [NPORT-1:0]    req_ready;
  logic [NPORT-1:0]    req_we;
  logic [NPORT*32-1:0] req_addr;
  logic [NPORT*4-1:0]  req_sel;
  logic [NPORT*32-1:0] req_wdata;
  logic [NPORT-1:0]    rsp_valid;
  logic [NPORT*32-1:0] rsp_rdata;
  logic                fsm_run;

  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, fsm_run
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, fsm_run
  );
endinterface

// File: rtl/data_ram_mp.sv
// Multi-port, word-interleaved banked data RAM for the multi-issue MEM stage.
//
// Each bank serves one access per cycle. When several ports hit the same
// bank, the lowest-numbered valid port (the oldest instruction) wins. Losers
// see req_ready low and must hold their request. Loads return data one cycle
// after transfer through a registered response channel.
//
// Optional feature macro: DATA_RAM_INIT_EN. When defined, an INIT/RUN
// sequencer zeroes every row of every bank after reset before the RAM
// accepts requests. When undefined, the RAM is usable on the first cycle
// out of reset and its contents start undefined.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   bus        data_ram_mp_if.slave request/response bundle
//   init_done  RAM is usable
module data_ram_mp #(
  parameter int NPORT      = 2,
  parameter int DEPTH_LOG2 = 12,
  parameter int BANK_LOG2  = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_ram_mp_if.slave      bus,
  output logic              init_done
);
  localparam int NBANK    = 1 << BANK_LOG2;
  localparam int ROW_BITS = DEPTH_LOG2 - BANK_LOG2;
  localparam int ROWS     = 1 << ROW_BITS;

  logic run;

`ifdef DATA_RAM_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state;
  logic [ROW_BITS-1:0] cnt;
  logic                init_wr;

  // The counter parks on the last row once RUN is reached; it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (cnt == ROW_BITS'(ROWS - 1)) begin
        state <= ST_RUN;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign run       = (state == ST_RUN);
  assign init_wr   = (state == ST_INIT);
  assign init_done = run;
`else
  assign run       = 1'b1;
  assign init_done = 1'b1;
`endif

  assign bus.fsm_run = run;

  // Address decode. Byte offset and bits above the word index are ignored.
  logic [NPORT-1:0][BANK_LOG2-1:0] p_bank;
  logic [NPORT-1:0][ROW_BITS-1:0]  p_row;
  logic                            unused_addr;

  always_comb begin
    p_bank = '0;
    p_row  = '0;
    for (int i = 0; i < NPORT; i++) begin
      p_bank[i] = bus.req_addr[32*i+2 +: BANK_LOG2];
      p_row[i]  = bus.req_addr[32*i+BANK_LOG2+2 +: ROW_BITS];
    end
  end

  assign unused_addr = ^bus.req_addr;

  // Fixed-priority arbitration: a port is blocked by any older valid port on
  // the same bank, whether or not that older port is itself ready. Because
  // port 0 is never blocked, the oldest port on each bank always wins.
  logic [NPORT-1:0] ready;
  logic [NPORT-1:0] xfer;

  always_comb begin
    ready = '0;
    for (int i = 0; i < NPORT; i++) begin
      ready[i] = run & ~rst;
      for (int j = 0; j < NPORT; j++) begin
        if (j < i && bus.req_valid[j] && p_bank[j] == p_bank[i]) begin
          ready[i] = 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = ready;
  assign xfer          = ready & bus.req_valid;

  // Route each transferring port to its bank. Granted ports always target
  // distinct banks, so at most one port matches any bank.
  logic [NBANK-1:0]               b_we;
  logic [NBANK-1:0][ROW_BITS-1:0] b_row;
  logic [NBANK-1:0][3:0]          b_sel;
  logic [NBANK-1:0][31:0]         b_wdata;
  logic [NBANK-1:0][31:0]         b_rdata;

  always_comb begin
    b_we    = '0;
    b_row   = '0;
    b_sel   = '0;
    b_wdata = '0;
    for (int b = 0; b < NBANK; b++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (xfer[i] && p_bank[i] == BANK_LOG2'(b)) begin
          b_we[b]    = bus.req_we[i];
          b_row[b]   = p_row[i];
          b_sel[b]   = bus.req_sel[4*i +: 4];
          b_wdata[b] = bus.req_wdata[32*i +: 32];
        end
      end
    end
  end

  // Storage: one array per bank per byte lane, so byte enables map onto
  // independent write strobes.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] lane [ROWS];

      always_ff @(posedge clk) begin
`ifdef DATA_RAM_INIT_EN
        if (init_wr) begin
          lane[cnt] <= 8'h00;
        end else
`endif
        if (b_we[b] && b_sel[b][l]) begin
          lane[b_row[b]] <= b_wdata[b][8*l +: 8];
        end
      end

      assign b_rdata[b][8*l +: 8] = lane[b_row[b]];
    end
  end

  // Registered read response; data is forced to zero when not valid.
  logic [NPORT-1:0]    rsp_v;
  logic [NPORT*32-1:0] rsp_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_v <= '0;
      rsp_d <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (xfer[i] && !bus.req_we[i]) begin
          rsp_v[i]           <= 1'b1;
          rsp_d[32*i +: 32]  <= b_rdata[p_bank[i]];
        end else begin
          rsp_v[i]           <= 1'b0;
          rsp_d[32*i +: 32]  <= 32'h0;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_rdata = rsp_d;
endmodule
